// File: rtl/privstatus_pkg.sv
// Shared config type, status field bit positions and the trap-context state record.
package privstatus_pkg;

   typedef struct packed {
      int unsigned XLEN;
      bit          U_SUPPORTED;
      bit          S_SUPPORTED;
      bit          H_SUPPORTED;
      logic [1:0]  M_MODE;
      logic [1:0]  S_MODE;
      logic [1:0]  U_MODE;
   } cvw_t;

   localparam cvw_t CVW_DEFAULT = '{XLEN: 64, U_SUPPORTED: 1'b1, S_SUPPORTED: 1'b1,
                                    H_SUPPORTED: 1'b1, M_MODE: 2'b11, S_MODE: 2'b01,
                                    U_MODE: 2'b00};

   localparam int MIE_BIT    = 3;
   localparam int SIE_BIT    = 1;
   localparam int MPIE_BIT   = 7;
   localparam int SPIE_BIT   = 5;
   localparam int SPP_BIT    = 8;
   localparam int MPP_LO     = 11;
   localparam int MPP_HI     = 12;
   localparam int MPRV_BIT   = 17;
   localparam int MPV64_BIT  = 39;
   localparam int MPV32H_BIT = 7;
   localparam int SPV_BIT    = 7;

   typedef struct packed {
      logic       mie;
      logic       sie;
      logic       mpie;
      logic       spie;
      logic       mprv;
      logic [1:0] mpp;
      logic       spp;
      logic       mpv;
      logic       spv;
      logic       vssie;
      logic       vsspie;
      logic       vsspp;
   } status_t;

   // MPP comes out of reset (and mret) pointing at the least-privileged mode present.
   function automatic logic [1:0] reset_mpp(cvw_t p);
      return p.U_SUPPORTED ? p.U_MODE : p.M_MODE;
   endfunction

endpackage

// File: rtl/privstatus_flopenl.sv
// Enabled flop with asynchronous active-low load of a constant init value.
module privstatus_flopenl #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] init,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  q <= init;
      else if (en) q <= d;

endmodule

// File: rtl/privstatus.sv
// Trap-context fields of mstatus/sstatus/hstatus/vsstatus: saved on trap, restored on xret.
module privstatus
   import privstatus_pkg::*;
#(
   parameter cvw_t P = CVW_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              StallW,
   input  logic              TrapM,
   input  logic              TrapToM,
   input  logic              TrapToHS,
   input  logic              TrapToVS,
   input  logic              mretM,
   input  logic              sretM,
   input  logic [1:0]        PrivilegeModeW,
   input  logic              VirtModeW,
   input  logic              WriteMSTATUSM,
   input  logic              WriteMSTATUSHM,
   input  logic              WriteSSTATUSM,
   input  logic              WriteHSTATUSM,
   input  logic              WriteVSSTATUSM,
   input  logic [P.XLEN-1:0] CSRWriteValM,
   output logic              STATUS_MIE,
   output logic              STATUS_SIE,
   output logic              STATUS_MPIE,
   output logic              STATUS_SPIE,
   output logic              STATUS_MPRV,
   output logic [1:0]        STATUS_MPP,
   output logic              STATUS_SPP,
   output logic              MSTATUS_MPV,
   output logic              HSTATUS_SPV,
   output logic              VSSTATUS_SIE,
   output logic              VSSTATUS_SPIE,
   output logic              VSSTATUS_SPP
);

   localparam logic [1:0] MPP_RST = reset_mpp(P);
   // Keeps the select in range on RV32, where the bit is never used.
   localparam int         MPV_IDX = (P.XLEN > MPV64_BIT) ? MPV64_BIT : 0;

   status_t    cur, nxt;
   logic [1:0] wr_mpp;
   logic       en;

   assign wr_mpp = CSRWriteValM[MPP_HI:MPP_LO];
   assign en     = ~StallW;

   always_comb begin
      nxt = cur;
      if (TrapM) begin
         if (TrapToM) begin
            nxt.mpp  = PrivilegeModeW;
            nxt.mpie = cur.mie;
            nxt.mie  = 1'b0;
            nxt.mpv  = VirtModeW;
         end else if (TrapToHS) begin
            nxt.spp  = PrivilegeModeW[0];
            nxt.spie = cur.sie;
            nxt.sie  = 1'b0;
            nxt.spv  = VirtModeW;
         end else if (TrapToVS) begin
            nxt.vsspp  = PrivilegeModeW[0];
            nxt.vsspie = cur.vssie;
            nxt.vssie  = 1'b0;
         end
      end else if (mretM) begin
         nxt.mie  = cur.mpie;
         nxt.mpie = 1'b1;
         nxt.mpv  = 1'b0;
         nxt.mpp  = MPP_RST;
         if (cur.mpp != P.M_MODE) nxt.mprv = 1'b0;
      end else if (sretM) begin
         if (VirtModeW) begin
            nxt.vssie  = cur.vsspie;
            nxt.vsspie = 1'b1;
            nxt.vsspp  = 1'b0;
         end else begin
            nxt.sie  = cur.spie;
            nxt.spie = 1'b1;
            nxt.spp  = 1'b0;
            nxt.spv  = 1'b0;
            nxt.mprv = 1'b0;
         end
      end else begin
         if (WriteMSTATUSM) begin
            nxt.mie  = CSRWriteValM[MIE_BIT];
            nxt.sie  = CSRWriteValM[SIE_BIT];
            nxt.mpie = CSRWriteValM[MPIE_BIT];
            nxt.spie = CSRWriteValM[SPIE_BIT];
            nxt.spp  = CSRWriteValM[SPP_BIT];
            nxt.mprv = CSRWriteValM[MPRV_BIT];
            // Reserved encoding and absent S mode leave MPP untouched.
            if (wr_mpp != 2'b10 && !(wr_mpp == P.S_MODE && !P.S_SUPPORTED)) nxt.mpp = wr_mpp;
            if (P.XLEN == 64) nxt.mpv = CSRWriteValM[MPV_IDX];
         end
         if (WriteMSTATUSHM && P.XLEN == 32) nxt.mpv = CSRWriteValM[MPV32H_BIT];
         if (WriteSSTATUSM) begin
            nxt.sie  = CSRWriteValM[SIE_BIT];
            nxt.spie = CSRWriteValM[SPIE_BIT];
            nxt.spp  = CSRWriteValM[SPP_BIT];
         end
         if (WriteHSTATUSM) nxt.spv = CSRWriteValM[SPV_BIT];
         if (WriteVSSTATUSM) begin
            nxt.vssie  = CSRWriteValM[SIE_BIT];
            nxt.vsspie = CSRWriteValM[SPIE_BIT];
            nxt.vsspp  = CSRWriteValM[SPP_BIT];
         end
      end
      if (!P.U_SUPPORTED) begin
         nxt.mpp  = P.M_MODE;
         nxt.mprv = 1'b0;
      end
      if (!P.S_SUPPORTED) begin
         nxt.sie  = 1'b0;
         nxt.spie = 1'b0;
         nxt.spp  = 1'b0;
      end
      if (!P.H_SUPPORTED) begin
         nxt.mpv    = 1'b0;
         nxt.spv    = 1'b0;
         nxt.vssie  = 1'b0;
         nxt.vsspie = 1'b0;
         nxt.vsspp  = 1'b0;
      end
   end

   privstatus_flopenl #(1) mie_reg    (.clk, .rst_n(reset), .en, .d(nxt.mie),    .init(1'b0),    .q(cur.mie));
   privstatus_flopenl #(1) sie_reg    (.clk, .rst_n(reset), .en, .d(nxt.sie),    .init(1'b0),    .q(cur.sie));
   privstatus_flopenl #(1) mpie_reg   (.clk, .rst_n(reset), .en, .d(nxt.mpie),   .init(1'b0),    .q(cur.mpie));
   privstatus_flopenl #(1) spie_reg   (.clk, .rst_n(reset), .en, .d(nxt.spie),   .init(1'b0),    .q(cur.spie));
   privstatus_flopenl #(1) mprv_reg   (.clk, .rst_n(reset), .en, .d(nxt.mprv),   .init(1'b0),    .q(cur.mprv));
   privstatus_flopenl #(2) mpp_reg    (.clk, .rst_n(reset), .en, .d(nxt.mpp),    .init(MPP_RST), .q(cur.mpp));
   privstatus_flopenl #(1) spp_reg    (.clk, .rst_n(reset), .en, .d(nxt.spp),    .init(1'b0),    .q(cur.spp));
   privstatus_flopenl #(1) mpv_reg    (.clk, .rst_n(reset), .en, .d(nxt.mpv),    .init(1'b0),    .q(cur.mpv));
   privstatus_flopenl #(1) spv_reg    (.clk, .rst_n(reset), .en, .d(nxt.spv),    .init(1'b0),    .q(cur.spv));
   privstatus_flopenl #(1) vssie_reg  (.clk, .rst_n(reset), .en, .d(nxt.vssie),  .init(1'b0),    .q(cur.vssie));
   privstatus_flopenl #(1) vsspie_reg (.clk, .rst_n(reset), .en, .d(nxt.vsspie), .init(1'b0),    .q(cur.vsspie));
   privstatus_flopenl #(1) vsspp_reg  (.clk, .rst_n(reset), .en, .d(nxt.vsspp),  .init(1'b0),    .q(cur.vsspp));

   assign STATUS_MIE    = cur.mie;
   assign STATUS_SIE    = cur.sie;
   assign STATUS_MPIE   = cur.mpie;
   assign STATUS_SPIE   = cur.spie;
   assign STATUS_MPRV   = cur.mprv;
   assign STATUS_MPP    = cur.mpp;
   assign STATUS_SPP    = cur.spp;
   assign MSTATUS_MPV   = cur.mpv;
   assign HSTATUS_SPV   = cur.spv;
   assign VSSTATUS_SIE  = cur.vssie;
   assign VSSTATUS_SPIE = cur.vsspie;
   assign VSSTATUS_SPP  = cur.vsspp;

endmodule

// File: tb/tb_privstatus.sv
// Scoreboard bench: model keeps whole mstatus/hstatus/vsstatus register images.
module tb_privstatus;
   import privstatus_pkg::*;

   localparam cvw_t CFG = '{XLEN: 32, U_SUPPORTED: 1'b1, S_SUPPORTED: 1'b1,
                            H_SUPPORTED: 1'b1, M_MODE: 2'b11, S_MODE: 2'b01, U_MODE: 2'b00};
   localparam logic [63:0] MS_MASK = 64'h201AA;
   localparam logic [63:0] SS_MASK = 64'h00122;

   logic        clk = 1'b0, reset = 1'b0;
   logic        StallW, TrapM, TrapToM, TrapToHS, TrapToVS, mretM, sretM, VirtModeW;
   logic [1:0]  PrivilegeModeW;
   logic        WriteMSTATUSM, WriteMSTATUSHM, WriteSSTATUSM, WriteHSTATUSM, WriteVSSTATUSM;
   logic [31:0] CSRWriteValM;
   logic        STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_MPRV, STATUS_SPP;
   logic [1:0]  STATUS_MPP;
   logic        MSTATUS_MPV, HSTATUS_SPV, VSSTATUS_SIE, VSSTATUS_SPIE, VSSTATUS_SPP;
   logic [12:0] dut_vec;

   logic [63:0] m, h, vs;
   logic [12:0] sb[$];
   int          checks = 0, errors = 0;

   privstatus #(.P(CFG)) dut (
      .clk(clk), .reset(reset), .StallW(StallW), .TrapM(TrapM), .TrapToM(TrapToM),
      .TrapToHS(TrapToHS), .TrapToVS(TrapToVS), .mretM(mretM), .sretM(sretM),
      .PrivilegeModeW(PrivilegeModeW), .VirtModeW(VirtModeW),
      .WriteMSTATUSM(WriteMSTATUSM), .WriteMSTATUSHM(WriteMSTATUSHM),
      .WriteSSTATUSM(WriteSSTATUSM), .WriteHSTATUSM(WriteHSTATUSM),
      .WriteVSSTATUSM(WriteVSSTATUSM), .CSRWriteValM(CSRWriteValM),
      .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .STATUS_MPIE(STATUS_MPIE),
      .STATUS_SPIE(STATUS_SPIE), .STATUS_MPRV(STATUS_MPRV), .STATUS_MPP(STATUS_MPP),
      .STATUS_SPP(STATUS_SPP), .MSTATUS_MPV(MSTATUS_MPV), .HSTATUS_SPV(HSTATUS_SPV),
      .VSSTATUS_SIE(VSSTATUS_SIE), .VSSTATUS_SPIE(VSSTATUS_SPIE), .VSSTATUS_SPP(VSSTATUS_SPP)
   );

   always #5 clk = ~clk;

   assign dut_vec = {STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_MPRV, STATUS_MPP,
                     STATUS_SPP, MSTATUS_MPV, HSTATUS_SPV, VSSTATUS_SIE, VSSTATUS_SPIE, VSSTATUS_SPP};

   function automatic logic [12:0] exp_vec();
      return {m[3], m[1], m[7], m[5], m[17], m[12:11], m[8], m[39], h[7], vs[1], vs[5], vs[8]};
   endfunction

   task automatic compare(input string name, input logic [12:0] got, input logic [12:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at %0t: got %b want %b (MIE SIE MPIE SPIE MPRV MPP[2] SPP MPV SPV VSSIE VSSPIE VSSPP)",
                  name, $time, got, want);
      end
   endtask

   task automatic model_reset();
      m = '0; h = '0; vs = '0;
      m[12:11] = CFG.U_MODE;
   endtask

   task automatic idle();
      StallW = 0; TrapM = 0; TrapToM = 0; TrapToHS = 0; TrapToVS = 0; mretM = 0; sretM = 0;
      PrivilegeModeW = 2'b11; VirtModeW = 0; WriteMSTATUSM = 0; WriteMSTATUSHM = 0;
      WriteSSTATUSM = 0; WriteHSTATUSM = 0; WriteVSSTATUSM = 0; CSRWriteValM = '0;
   endtask

   // tgt: 0=M 1=HS 2=VS; wr: 0 none 1 mstatus 2 mstatush 3 sstatus 4 hstatus 5 vsstatus
   task automatic step(input bit stall, input bit trap, input int tgt, input bit mret, input bit sret,
                       input logic [1:0] priv, input bit virt, input int wr, input logic [31:0] d);
      logic [63:0] dd;
      @(negedge clk);
      StallW = stall; TrapM = trap; TrapToM = trap && tgt == 0; TrapToHS = trap && tgt == 1;
      TrapToVS = trap && tgt == 2; mretM = mret; sretM = sret; PrivilegeModeW = priv;
      VirtModeW = virt; WriteMSTATUSM = wr == 1; WriteMSTATUSHM = wr == 2; WriteSSTATUSM = wr == 3;
      WriteHSTATUSM = wr == 4; WriteVSSTATUSM = wr == 5; CSRWriteValM = d;
      dd = {32'b0, d};
      if (stall) begin
      end else if (trap) begin
         case (tgt)
            0: begin m[12:11] = priv; m[7] = m[3]; m[3] = 0; m[39] = virt; end
            1: begin m[8] = priv[0]; m[5] = m[1]; m[1] = 0; h[7] = virt; end
            default: begin vs[8] = priv[0]; vs[5] = vs[1]; vs[1] = 0; end
         endcase
      end else if (mret) begin
         if (m[12:11] != 2'b11) m[17] = 0;
         m[3] = m[7]; m[7] = 1; m[39] = 0; m[12:11] = CFG.U_MODE;
      end else if (sret) begin
         if (virt) begin vs[1] = vs[5]; vs[5] = 1; vs[8] = 0; end
         else begin m[1] = m[5]; m[5] = 1; m[8] = 0; h[7] = 0; m[17] = 0; end
      end else begin
         case (wr)
            1: begin
               m = (m & ~MS_MASK) | (dd & MS_MASK);
               if (dd[12:11] != 2'b10) m[12:11] = dd[12:11];
            end
            2: m[39] = dd[7];
            3: m = (m & ~SS_MASK) | (dd & SS_MASK);
            4: h[7] = dd[7];
            5: vs = (vs & ~SS_MASK) | (dd & SS_MASK);
            default: ;
         endcase
      end
      sb.push_back(exp_vec());
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      idle();
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare("async_reset", dut_vec, exp_vec());
      #1 reset = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) compare("status", dut_vec, sb.pop_front());
   end

   initial begin
      logic [1:0] privs [3] = '{2'b00, 2'b01, 2'b11};
      idle();
      model_reset();
      #3 compare("reset_state", dut_vec, exp_vec());
      @(negedge clk) reset = 1'b1;

      // mstatus write then mret
      step(0, 0, 0, 0, 0, 2'b11, 0, 1, 32'h88);
      step(0, 0, 0, 1, 0, 2'b11, 0, 0, 0);
      // trap from U to M, then mret clears MPRV
      step(0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
      step(0, 0, 0, 0, 0, 2'b11, 0, 1, 32'h20000);
      step(0, 0, 0, 1, 0, 2'b11, 0, 0, 0);
      // VS trap and sret with V=1
      step(0, 0, 0, 0, 0, 2'b01, 1, 5, 32'h2);
      step(0, 1, 2, 0, 0, 2'b01, 1, 0, 0);
      step(0, 0, 0, 0, 1, 2'b01, 1, 0, 0);
      // reserved MPP write; trap beats a concurrent CSR write
      step(0, 0, 0, 0, 0, 2'b11, 0, 1, 32'h1800);
      step(0, 0, 0, 0, 0, 2'b11, 0, 1, 32'h1000);
      step(0, 1, 0, 0, 0, 2'b01, 0, 1, 32'h0);
      // stalled HS trap, then released
      step(0, 0, 0, 0, 0, 2'b11, 0, 3, 32'h2);
      step(1, 1, 1, 0, 0, 2'b00, 1, 0, 0);
      step(0, 1, 1, 0, 0, 2'b00, 1, 0, 0);
      // mstatush MPV, mret from S clears it, then asynchronous reset
      step(0, 0, 0, 0, 0, 2'b11, 0, 2, 32'h80);
      step(0, 0, 0, 0, 0, 2'b11, 0, 1, 32'h20808);
      step(0, 0, 0, 1, 0, 2'b11, 0, 0, 0);
      step(0, 0, 0, 0, 0, 2'b11, 0, 1, 32'h21888);
      async_reset_check();

      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2),
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, privs[$urandom_range(0, 2)],
              $urandom_range(0, 1) == 1, $urandom_range(0, 5), $urandom);
         if (i == 700) async_reset_check();
      end

      @(negedge clk) idle();
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/privstatus.md
Name: privstatus

Overview:
- Owns the trap-context fields of mstatus, sstatus, hstatus and vsstatus: xIE, xPIE, xPP, MPRV, MPV and SPV.
- On a trap it saves the current privilege/virtualization state and interrupt enables; on mret/sret it restores them.
- It is the producer of STATUS_MPP, STATUS_SPP, VSSTATUS_SPP, MSTATUS_MPV and HSTATUS_SPV, which the privilege-mode tracker consumes. It sits in the privileged unit beside the CSR file and commits in the M/W boundary.

Parameters:
- P, (none; cvw_t config), supplies XLEN, U_SUPPORTED, S_SUPPORTED, H_SUPPORTED, M_MODE, S_MODE, U_MODE.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- StallW  in  1  blocks all state updates when high
- TrapM  in  1  trap committing this cycle
- TrapToM, TrapToHS, TrapToVS  in  1 each  resolved trap target, one-hot when TrapM
- mretM, sretM  in  1 each  return committing
- PrivilegeModeW  in  2  current privilege
- VirtModeW  in  1  current V
- WriteMSTATUSM, WriteMSTATUSHM, WriteSSTATUSM, WriteHSTATUSM, WriteVSSTATUSM  in  1 each  CSR write strobes
- CSRWriteValM  in  XLEN  CSR write data
- STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_MPRV  out  1 each
- STATUS_MPP  out  2
- STATUS_SPP  out  1
- MSTATUS_MPV, HSTATUS_SPV  out  1 each
- VSSTATUS_SIE, VSSTATUS_SPIE, VSSTATUS_SPP  out  1 each

Behaviour:
- All fields are flops enabled by ~StallW. An update committed in cycle N is visible at the outputs in cycle N+1. Outputs are registered only, with no combinational path from inputs.
- Reset (asynchronous, reset=0):
  - All 1-bit outputs are 0.
  - STATUS_MPP = U_MODE if U_SUPPORTED, else M_MODE.
- Priority per cycle: TrapM > mretM > sretM > CSR writes. A CSR write is ignored in any cycle where TrapM, mretM or sretM is asserted.
- Trap to M: MPP←PrivilegeModeW, MPIE←MIE, MIE←0, MPV←VirtModeW.
- Trap to HS: SPP←PrivilegeModeW[0], SPIE←SIE, SIE←0, SPV←VirtModeW.
- Trap to VS: VSSPP←PrivilegeModeW[0], VSSPIE←VSSIE, VSSIE←0. M/HS fields are untouched.
- mret:
  - MIE←MPIE, MPIE←1, MPV←0.
  - MPP←U_MODE if U_SUPPORTED, else M_MODE.
  - MPRV←0 if the old MPP≠M_MODE.
- sret with VirtModeW=0: SIE←SPIE, SPIE←1, SPP←0, SPV←0, MPRV←0.
- sret with VirtModeW=1: VSSIE←VSSPIE, VSSPIE←1, VSSPP←0. HS fields are unchanged.
- mstatus write: MIE[3], SIE[1], MPIE[7], SPIE[5], SPP[8], MPP[12:11], MPRV[17]. When XLEN=64, also MPV[39].
- mstatush write (XLEN=32 only): MPV←CSRWriteValM[7].
- sstatus write: SIE, SPIE and SPP only.
- hstatus write: SPV←CSRWriteValM[7].
- vsstatus write: SIE[1], SPIE[5] and SPP[8] into the VS fields.
- WARL rules:
  - MPP write of 2'b10, or of S_MODE when !S_SUPPORTED, keeps the old value.
  - When !U_SUPPORTED, MPP is hardwired to M_MODE and MPRV to 0.
  - When !S_SUPPORTED, SIE, SPIE and SPP are hardwired to 0.
  - When !H_SUPPORTED, MPV, SPV and all VS fields are hardwired to 0.
- Stall: when StallW=1, nothing changes even if TrapM/mretM/sretM/write strobes are high.
- Reset asserted mid-sequence forces reset values immediately; the return state is not preserved.

Decomposition:
- Shared package (cvw): localparams for mstatus/hstatus/vsstatus bit positions (MIE=3, SIE=1, MPIE=7, SPIE=5, SPP=8, MPP=12:11, MPRV=17, MPV64=39, MPV32H=7, SPV=7) and the reset MPP value.
- No sub-module. Each field uses a flopenl instance with an asynchronous active-low clear.

Test Plan:
- Reset release, U supported → MPP=2'b00, all enables 0; write mstatus 0x88, then mret → MIE=1, MPIE=1, MPP=00 next cycle.
- PrivilegeModeW=U, MIE=1, TrapToM → MPP=00, MPIE=1, MIE=0; then mret with MPP=00 and MPRV=1 → MPRV=0.
- VirtModeW=1, PrivilegeModeW=S, VSSIE=1, TrapToVS → VSSPP=1, VSSPIE=1, VSSIE=0, SPP/SPIE unchanged; sret with V=1 → VSSIE=1, VSSPP=0.
- mstatus write MPP=2'b10 while MPP=11 → stays 11; TrapM together with WriteMSTATUSM=0 data → trap update only.
- StallW=1 with TrapToHS, SIE=1 → SIE stays 1, SPIE unchanged; StallW→0 with trap still present → SPIE=1, SIE=0, SPV=VirtModeW.
- XLEN=32, H: WriteMSTATUSHM bit7=1 → MPV=1; mret with MPP=S → MPV=0; drive reset low mid-run → all fields at reset values without a clock edge.
